// File: rtl/xcvr_mgmt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// xcvr_mgmt_pkg
// Shared state type, error read value and packed-slice helper for the
// transceiver management-port arbiter.
// Revision: 1.0
// ============================================================================
package xcvr_mgmt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Wide enough for any realistic management bus; users slice the low bits.
  localparam int                     RDATA_MAX_W = 256;
  localparam logic [RDATA_MAX_W-1:0] RDATA_ERR   = '1;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xcvr_mgmt_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick
// Combinational round-robin selector: first pending index at or after the
// pointer, wrapping.
// Revision: 1.0
// ============================================================================
module rr_pick
  import xcvr_mgmt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_vld,
  output logic [IDX_W-1:0]   o_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;

  // Lower copy masked below the pointer, upper copy intact: the lowest set
  // bit of the doubled vector is the wrapped round-robin winner.
  always_comb begin
    w_dbl = {i_pend, i_pend};
    for (int b = 0; b < NUM_REQ; b++) begin
      if (b < int'(i_ptr)) w_dbl[b] = 1'b0;
    end
    o_vld = 1'b0;
    o_idx = '0;
    for (int b = 2*NUM_REQ-1; b >= 0; b--) begin
      if (w_dbl[b]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(b % NUM_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xcvr_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// xcvr_mgmt_arbiter
// Round-robin sharing of one Avalon-MM transceiver management port between
// several requesters, with per-transfer stall timeout. All outputs registered.
// Revision: 1.0
// ============================================================================
module xcvr_mgmt_arbiter
  import xcvr_mgmt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_error,
  output logic [ADDR_W-1:0]         mgmt_address,
  output logic                      mgmt_read,
  output logic                      mgmt_write,
  output logic [DATA_W-1:0]         mgmt_writedata,
  input  logic [DATA_W-1:0]         mgmt_readdata,
  input  logic                      mgmt_waitrequest
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t              r_state,  w_state_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]    r_gnt,    w_gnt_nxt;
  logic [TMO_W-1:0]    r_tmo_cnt, w_tmo_nxt;
  logic                r_mgmt_read,  w_rd_nxt;
  logic                r_mgmt_write, w_wr_nxt;
  logic [ADDR_W-1:0]   r_mgmt_address, w_addr_nxt;
  logic [DATA_W-1:0]   r_mgmt_writedata, w_wdata_nxt;
  logic [NUM_REQ-1:0]  r_req_wait, w_wait_nxt;
  logic [DATA_W-1:0]   r_readdata, w_rdata_nxt;
  logic [NUM_REQ-1:0]  r_error, w_err_nxt;

  logic [NUM_REQ-1:0]  w_pend;
  logic                w_pick_vld;
  logic [IDX_W-1:0]    w_pick_idx;

  assign w_pend = req_read | req_write;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_pend (w_pend),
    .i_ptr  (r_rr_ptr),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gnt_nxt    = r_gnt;
    w_tmo_nxt    = r_tmo_cnt;
    w_rd_nxt     = r_mgmt_read;
    w_wr_nxt     = r_mgmt_write;
    w_addr_nxt   = r_mgmt_address;
    w_wdata_nxt  = r_mgmt_writedata;
    w_wait_nxt   = '1;
    w_rdata_nxt  = r_readdata;
    w_err_nxt    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt   = w_pick_idx;
          w_wr_nxt    = req_write[w_pick_idx];
          w_rd_nxt    = ~req_write[w_pick_idx];
          w_addr_nxt  = req_address[slice_lo(int'(w_pick_idx), ADDR_W) +: ADDR_W];
          w_wdata_nxt = req_writedata[slice_lo(int'(w_pick_idx), DATA_W) +: DATA_W];
          w_tmo_nxt   = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // A slave accept on the final allowed cycle still wins over the abort.
        if (!mgmt_waitrequest) begin
          w_rd_nxt          = 1'b0;
          w_wr_nxt          = 1'b0;
          w_rdata_nxt       = r_mgmt_write ? '0 : mgmt_readdata;
          w_wait_nxt[r_gnt] = 1'b0;
          w_state_nxt       = DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_rd_nxt          = 1'b0;
          w_wr_nxt          = 1'b0;
          w_rdata_nxt       = RDATA_ERR[DATA_W-1:0];
          w_wait_nxt[r_gnt] = 1'b0;
          w_err_nxt[r_gnt]  = 1'b1;
          w_state_nxt       = DONE;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        w_rr_ptr_nxt = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_rr_ptr         <= '0;
      r_gnt            <= '0;
      r_tmo_cnt        <= '0;
      r_mgmt_read      <= 1'b0;
      r_mgmt_write     <= 1'b0;
      r_mgmt_address   <= '0;
      r_mgmt_writedata <= '0;
      r_req_wait       <= '1;
      r_readdata       <= '0;
      r_error          <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_rr_ptr         <= w_rr_ptr_nxt;
      r_gnt            <= w_gnt_nxt;
      r_tmo_cnt        <= w_tmo_nxt;
      r_mgmt_read      <= w_rd_nxt;
      r_mgmt_write     <= w_wr_nxt;
      r_mgmt_address   <= w_addr_nxt;
      r_mgmt_writedata <= w_wdata_nxt;
      r_req_wait       <= w_wait_nxt;
      r_readdata       <= w_rdata_nxt;
      r_error          <= w_err_nxt;
    end
  end

  assign req_waitrequest = r_req_wait;
  assign req_readdata    = r_readdata;
  assign req_error       = r_error;
  assign mgmt_address    = r_mgmt_address;
  assign mgmt_read       = r_mgmt_read;
  assign mgmt_write      = r_mgmt_write;
  assign mgmt_writedata  = r_mgmt_writedata;

endmodule
`default_nettype wire

// File: tb/tb_xcvr_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// tb_xcvr_mgmt_arbiter
// Directed bench for the management-port arbiter with a simple stalling slave.
// Revision: 1.0
// ============================================================================
module tb_xcvr_mgmt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_read, req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_error;
  logic [ADDR_W-1:0]         mgmt_address;
  logic                      mgmt_read, mgmt_write;
  logic [DATA_W-1:0]         mgmt_writedata;
  logic [DATA_W-1:0]         mgmt_readdata;
  logic                      mgmt_waitrequest;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Slave: stalls slv_wait strobe cycles (or forever when slv_stall).
  int          slv_wait  = 0;
  bit          slv_stall = 1'b0;
  int          slv_cnt   = 0;
  logic [DATA_W-1:0] slv_rdata = '0;

  logic              log_we   [0:63];
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [DATA_W-1:0] log_data [0:63];
  int                log_n = 0;

  assign mgmt_waitrequest = slv_stall | (slv_cnt < slv_wait);
  assign mgmt_readdata    = slv_rdata;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    slv_cnt <= (mgmt_read | mgmt_write) ? slv_cnt + 1 : 0;
    if ((mgmt_read | mgmt_write) && !mgmt_waitrequest && log_n < 64) begin
      log_we[log_n]   <= mgmt_write;
      log_addr[log_n] <= mgmt_address;
      log_data[log_n] <= mgmt_writedata;
      log_n           <= log_n + 1;
    end
  end

  xcvr_mgmt_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_writedata    (req_writedata),
    .req_waitrequest  (req_waitrequest),
    .req_readdata     (req_readdata),
    .req_error        (req_error),
    .mgmt_address     (mgmt_address),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_read[i]                    = rd;
    req_write[i]                   = wr;
    req_address[i*ADDR_W +: ADDR_W] = a;
    req_writedata[i*DATA_W +: DATA_W] = d;
  endtask

  // Waits (bounded) for requester g's completion; returns at that negedge.
  task automatic wait_done(input int g, input string tag, output int strobes);
    bit ok = 1'b0;
    strobes = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_waitrequest[g] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (mgmt_read | mgmt_write) strobes++;
    end
    chk({tag, "_completes"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int st;
    int base;

    reset_n       = 1'b0;
    req_read      = '0;
    req_write     = '0;
    req_address   = '0;
    req_writedata = '0;
    repeat (3) @(negedge clk);

    chk("rst_mgmt_read",  64'(mgmt_read), 64'd0);
    chk("rst_mgmt_write", 64'(mgmt_write), 64'd0);
    chk("rst_mgmt_addr",  64'(mgmt_address), 64'd0);
    chk("rst_waitreq",    64'(req_waitrequest), 64'hF);
    chk("rst_readdata",   64'(req_readdata), 64'd0);
    chk("rst_error",      64'(req_error), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Round-robin: all four write at once, zero-wait slave.
    base     = log_n;
    slv_wait = 0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, ADDR_W'(9'h10 + i), 32'hA000_0000 + i);
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_done(i, "rr", st);
      chk("rr_waitreq_onehot", 64'(req_waitrequest), 64'(~(4'b1 << i) & 4'hF));
      chk("rr_log_count",      64'(log_n - base), 64'(i + 1));
      chk("rr_log_addr",       64'(log_addr[base+i]), 64'(9'h10 + i));
      chk("rr_log_data",       64'(log_data[base+i]), 64'(32'hA000_0000 + i));
      chk("rr_log_we",         64'(log_we[base+i]), 64'd1);
      set_req(i, 1'b0, 1'b0, '0, '0);
    end

    // Single read from requester 2, slave waits 3 cycles.
    @(negedge clk);
    base      = log_n;
    slv_wait  = 3;
    slv_rdata = 32'h1234_5678;
    set_req(2, 1'b1, 1'b0, 9'h05, '0);
    wait_done(2, "rd", st);
    chk("rd_strobe_cycles", 64'(st), 64'd4);
    chk("rd_readdata",      64'(req_readdata), 64'h1234_5678);
    chk("rd_error",         64'(req_error), 64'd0);
    chk("rd_waitreq",       64'(req_waitrequest), 64'b1011);
    chk("rd_log_addr",      64'(log_addr[base]), 64'h05);
    chk("rd_log_we",        64'(log_we[base]), 64'd0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rd_waitreq_high_again", 64'(req_waitrequest), 64'hF);

    // Fairness after wrap: pointer now 3; requesters 0 and 3 contend.
    base      = log_n;
    slv_wait  = 0;
    slv_rdata = 32'h0000_0BEE;
    set_req(0, 1'b1, 1'b0, 9'h20, '0);
    set_req(3, 1'b1, 1'b0, 9'h23, '0);
    wait_done(3, "wrap3", st);
    chk("wrap_first_waitreq", 64'(req_waitrequest), 64'b0111);
    chk("wrap_first_addr",    64'(log_addr[base]), 64'h23);
    set_req(3, 1'b0, 1'b0, '0, '0);
    wait_done(0, "wrap0", st);
    chk("wrap_second_addr",   64'(log_addr[base+1]), 64'h20);
    chk("wrap_second_rdata",  64'(req_readdata), 64'h0BEE);
    set_req(0, 1'b0, 1'b0, '0, '0);

    // Requester 1 asserts read+write, drops both after one cycle.
    @(negedge clk);
    base     = log_n;
    slv_wait = 2;
    set_req(1, 1'b1, 1'b1, 9'h31, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rw_latency_write", 64'(mgmt_write), 64'd1);
    chk("rw_no_read",       64'(mgmt_read), 64'd0);
    chk("rw_addr",          64'(mgmt_address), 64'h31);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_done(1, "rw", st);
    chk("rw_readdata_zero", 64'(req_readdata), 64'd0);
    chk("rw_log_we",        64'(log_we[base]), 64'd1);
    chk("rw_log_data",      64'(log_data[base]), 64'hCAFE_F00D);
    repeat (4) @(negedge clk);
    chk("rw_single_access", 64'(log_n - base), 64'd1);

    // Timeout on requester 2, requester 3 waiting behind it.
    base      = log_n;
    slv_stall = 1'b1;
    set_req(2, 1'b1, 1'b0, 9'h42, '0);
    set_req(3, 1'b0, 1'b1, 9'h43, 32'h5555_AAAA);
    wait_done(2, "tmo", st);
    chk("tmo_strobe_cycles", 64'(st), 64'(TIMEOUT));
    chk("tmo_readdata",      64'(req_readdata), 64'hFFFF_FFFF);
    chk("tmo_error",         64'(req_error), 64'b0100);
    set_req(2, 1'b0, 1'b0, '0, '0);
    slv_stall = 1'b0;
    slv_wait  = 0;
    @(negedge clk);
    chk("tmo_error_pulse",   64'(req_error), 64'd0);
    wait_done(3, "tmo_next", st);
    chk("tmo_next_error",    64'(req_error), 64'd0);
    chk("tmo_next_addr",     64'(log_addr[base]), 64'h43);
    set_req(3, 1'b0, 1'b0, '0, '0);

    // Reset in the middle of a stalled transfer.
    @(negedge clk);
    slv_stall = 1'b1;
    set_req(1, 1'b1, 1'b0, 9'h51, '0);
    repeat (5) @(negedge clk);
    chk("rstmid_pre_read", 64'(mgmt_read), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmid_read",    64'(mgmt_read), 64'd0);
    chk("rstmid_write",   64'(mgmt_write), 64'd0);
    chk("rstmid_waitreq", 64'(req_waitrequest), 64'hF);
    set_req(1, 1'b0, 1'b0, '0, '0);
    slv_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base = log_n;
    set_req(0, 1'b1, 1'b0, 9'h60, '0);
    set_req(2, 1'b1, 1'b0, 9'h62, '0);
    wait_done(0, "rstmid_g0", st);
    chk("rstmid_first_addr", 64'(log_addr[base]), 64'h60);
    set_req(0, 1'b0, 1'b0, '0, '0);
    wait_done(2, "rstmid_g2", st);
    chk("rstmid_second_addr", 64'(log_addr[base+1]), 64'h62);
    set_req(2, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
